// File: rtl/onehot_pkg.sv
// Shared scan-direction type and bit-reversal helper for the one-hot/multi-hot blocks.
// Ports: none (package).
// Latency: n/a (types and combinational helpers only). Backpressure: n/a.
package onehot_pkg;

    typedef enum logic {
        SCAN_LSB = 1'b0,
        SCAN_MSB = 1'b1
    } scan_dir_t;

    // Widest vector bit_reverse_f handles; callers zero-extend into it and
    // cast the result back down to their own width.
    localparam int REV_MAX_W = 256;

    // Mirrors the low w bits of v (bit i -> bit w-1-i); bits at and above w return 0.
    function automatic logic [REV_MAX_W-1:0] bit_reverse_f(
        input logic [REV_MAX_W-1:0] v,
        input int                   w
    );
        logic [REV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < REV_MAX_W; i++) begin
            if (i < w) begin
                r[w-1-i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_encoder_base.sv
// One-hot to binary index encoder (IMPLEMENTATION 0 = OR-loop, 1 = column-mask table).
// Ports: onehot (WIDTH, one-hot or zero), idx (index of the set bit, 0 when none), enc_vld (any bit set).
// Latency: purely combinational. Backpressure: none.
module onehot_encoder_base #(
    parameter  int WIDTH          = 32,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     onehot,
    output logic [WIDTH_LOG-1:0] idx,
    output logic                 enc_vld
);

    assign enc_vld = |onehot;

    // Bit b of column mask: set wherever index i has bit b set.
    function automatic logic [WIDTH-1:0] col_mask(input int b);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    generate
        if (IMPLEMENTATION == 0) begin : g_loop
            // OR of every set position's index; exact for one-hot input,
            // and no priority chain is built.
            always_comb begin
                idx = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (onehot[i]) begin
                        idx = idx | WIDTH_LOG'(i);
                    end
                end
            end
        end else if (IMPLEMENTATION == 1) begin : g_table
            for (genvar b = 0; b < WIDTH_LOG; b++) begin : g_bit
                localparam logic [WIDTH-1:0] COL = col_mask(b);
                assign idx[b] = |(onehot & COL);
            end
        end else begin : g_bad_impl
            $fatal(1, "onehot_encoder_base: IMPLEMENTATION must be 0 or 1");
        end
    endgenerate

endmodule

// File: rtl/multihot_index_scanner.sv
// Streams the index of every set bit of an accepted multi-hot vector, one index per output transfer.
// Ports: clk/rst; in_vld/in_rdy/in_vec input handshake; out_vld/out_rdy/enc_idx/out_lst output handshake; busy.
// Latency: first index the cycle after acceptance, then one per cycle; out_rdy=0 holds everything, in_rdy=0 while busy.
module multihot_index_scanner
    import onehot_pkg::*;
#(
    parameter  int        WIDTH          = 32,
    parameter  int        IMPLEMENTATION = 0,
    parameter  scan_dir_t DIRECTION      = SCAN_LSB,
    localparam int        WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [WIDTH-1:0]     in_vec,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [WIDTH_LOG-1:0] enc_idx,
    output logic                 out_lst,
    output logic                 busy
);

    logic [WIDTH-1:0] msk;   // bits not yet emitted
    logic [WIDTH-1:0] sel;   // bit being presented this cycle
    logic [WIDTH-1:0] rest;  // what remains after sel transfers
    logic             enc_vld;

    generate
        if (WIDTH < 2 || WIDTH > REV_MAX_W) begin : g_bad_width
            $fatal(1, "multihot_index_scanner: WIDTH out of range");
        end

        if (DIRECTION == SCAN_LSB) begin : g_lsb
            // Two's-complement trick keeps only the lowest set bit.
            assign sel = msk & (~msk + WIDTH'(1));
        end else begin : g_msb
            // Mirror, take the lowest bit, mirror back = highest set bit.
            logic [WIDTH-1:0] rev;
            logic [WIDTH-1:0] rev_sel;
            assign rev     = WIDTH'(bit_reverse_f(REV_MAX_W'(msk), WIDTH));
            assign rev_sel = rev & (~rev + WIDTH'(1));
            assign sel     = WIDTH'(bit_reverse_f(REV_MAX_W'(rev_sel), WIDTH));
        end
    endgenerate

    onehot_encoder_base #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_enc (
        .onehot  (sel),
        .idx     (enc_idx),
        .enc_vld (enc_vld)
    );

    assign rest    = msk & ~sel;
    assign busy    = |msk;
    assign out_vld = busy;
    assign out_lst = busy & ~(|rest);
    // Accept a new vector in the same cycle the final index leaves, so
    // consecutive vectors stream without an idle cycle.
    assign in_rdy  = ~busy | (out_rdy & out_lst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msk <= '0;
        end else if (in_vld && in_rdy) begin
            msk <= in_vec;
        end else if (out_vld && out_rdy) begin
            msk <= rest;
        end
    end

    a_sel_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(sel));
    a_enc_vld     : assert property (@(posedge clk) disable iff (rst) enc_vld == busy);
    a_idx_stable  : assert property (@(posedge clk) disable iff (rst)
                                     (out_vld && !out_rdy) |=> $stable(enc_idx));
    a_accept_busy : assert property (@(posedge clk) disable iff (rst)
                                     (in_vld && in_rdy && busy) |-> (out_rdy && out_lst));

endmodule

// File: tb/tb_multihot_index_scanner.sv
// Lock-step bench for four scanner configurations: 8-bit LSB/loop, 8-bit MSB/table, 5-bit LSB/loop, 5-bit MSB/table.
// Ports: none. A queue-based reference model per instance is checked on every falling edge.
// Directed sequences plus a randomized phase; one summary line at the end.
module tb_multihot_index_scanner;
    import onehot_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic [7:0] in_vec;
    logic       out_rdy;

    logic [3:0] in_rdy_a;
    logic [3:0] out_vld_a;
    logic [3:0] out_lst_a;
    logic [3:0] busy_a;
    logic [2:0] idx_a [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int exp_q   [4][$];
    int log_idx [4][$];
    int log_lst [4][$];
    int log_rdy [4][$];
    int log_cyc [4][$];

    int  mon_n;
    bit  mon_rdy;
    int  mon_w;
    int  mon_b;

    always #5 clk = ~clk;

    multihot_index_scanner #(.WIDTH(8), .IMPLEMENTATION(0), .DIRECTION(SCAN_LSB)) u_8l (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_a[0]), .in_vec(in_vec),
        .out_vld(out_vld_a[0]), .out_rdy(out_rdy), .enc_idx(idx_a[0]),
        .out_lst(out_lst_a[0]), .busy(busy_a[0]));

    multihot_index_scanner #(.WIDTH(8), .IMPLEMENTATION(1), .DIRECTION(SCAN_MSB)) u_8m (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_a[1]), .in_vec(in_vec),
        .out_vld(out_vld_a[1]), .out_rdy(out_rdy), .enc_idx(idx_a[1]),
        .out_lst(out_lst_a[1]), .busy(busy_a[1]));

    multihot_index_scanner #(.WIDTH(5), .IMPLEMENTATION(0), .DIRECTION(SCAN_LSB)) u_5l (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_a[2]), .in_vec(in_vec[4:0]),
        .out_vld(out_vld_a[2]), .out_rdy(out_rdy), .enc_idx(idx_a[2]),
        .out_lst(out_lst_a[2]), .busy(busy_a[2]));

    multihot_index_scanner #(.WIDTH(5), .IMPLEMENTATION(1), .DIRECTION(SCAN_MSB)) u_5m (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_a[3]), .in_vec(in_vec[4:0]),
        .out_vld(out_vld_a[3]), .out_rdy(out_rdy), .enc_idx(idx_a[3]),
        .out_lst(out_lst_a[3]), .busy(busy_a[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the scanner is a list of pending indices. Everything
    // below is evaluated on the falling edge for the upcoming rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                exp_q[d].delete();
                chk($sformatf("u%0d_rst_vld", d), out_vld_a[d], 0);
                chk($sformatf("u%0d_rst_rdy", d), in_rdy_a[d], 1);
                chk($sformatf("u%0d_rst_busy", d), busy_a[d], 0);
                chk($sformatf("u%0d_rst_lst", d), out_lst_a[d], 0);
                chk($sformatf("u%0d_rst_idx", d), idx_a[d], 0);
            end else begin
                mon_n   = exp_q[d].size();
                mon_rdy = (mon_n == 0) || (out_rdy && mon_n == 1);
                chk($sformatf("u%0d_vld", d), out_vld_a[d], mon_n != 0);
                chk($sformatf("u%0d_busy", d), busy_a[d], mon_n != 0);
                chk($sformatf("u%0d_in_rdy", d), in_rdy_a[d], mon_rdy);
                if (mon_n > 0) begin
                    chk($sformatf("u%0d_idx", d), idx_a[d], exp_q[d][0]);
                    chk($sformatf("u%0d_lst", d), out_lst_a[d], mon_n == 1);
                    if (out_rdy) begin
                        log_idx[d].push_back(int'(idx_a[d]));
                        log_lst[d].push_back(int'(out_lst_a[d]));
                        log_rdy[d].push_back(int'(in_rdy_a[d]));
                        log_cyc[d].push_back(cyc);
                        void'(exp_q[d].pop_front());
                    end
                end
                if (in_vld && mon_rdy) begin
                    mon_w = (d < 2) ? 8 : 5;
                    for (int i = 0; i < mon_w; i++) begin
                        mon_b = d[0] ? (mon_w - 1 - i) : i;
                        if (in_vec[mon_b]) exp_q[d].push_back(mon_b);
                    end
                end
            end
        end
    end

    task automatic clr_logs();
        for (int d = 0; d < 4; d++) begin
            log_idx[d].delete();
            log_lst[d].delete();
            log_rdy[d].delete();
            log_cyc[d].delete();
        end
    endtask

    // Compare the transfer log of instance d against expected indices and
    // last flags; in_rdy must be high exactly on last-index transfers.
    task automatic check_seq(input int d, input string tag, input int e[$], input int l[$],
                             input bit consec);
        chk({tag, "_count"}, log_idx[d].size(), e.size());
        for (int k = 0; k < e.size() && k < log_idx[d].size(); k++) begin
            chk($sformatf("%s_idx%0d", tag, k), log_idx[d][k], e[k]);
            chk($sformatf("%s_lst%0d", tag, k), log_lst[d][k], l[k]);
            chk($sformatf("%s_rdy%0d", tag, k), log_rdy[d][k], l[k]);
            if (consec && k > 0)
                chk($sformatf("%s_gap%0d", tag, k), log_cyc[d][k] - log_cyc[d][k-1], 1);
        end
    endtask

    task automatic send(input logic [7:0] v);
        in_vld = 1'b1;
        in_vec = v;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_vec = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int e[$];
        int l[$];
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_vec  = '0;
        out_rdy = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("idle_in_rdy", in_rdy_a[0], 1);
        chk("idle_out_vld", out_vld_a[0], 0);
        chk("idle_busy", busy_a[0], 0);

        // 1010_0110 streamed both ways.
        clr_logs();
        send(8'hA6);
        idle(8);
        e = '{1, 2, 5, 7}; l = '{0, 0, 0, 1};
        check_seq(0, "a6_lsb", e, l, 1'b1);
        e = '{7, 5, 2, 1};
        check_seq(1, "a6_msb", e, l, 1'b1);

        // Back-to-back vectors with in_vld held; second accepted on index 7.
        clr_logs();
        in_vld = 1'b1;
        in_vec = 8'h81;
        @(posedge clk);
        #1;
        in_vec = 8'h10;
        @(posedge clk);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        idle(6);
        e = '{0, 7, 4}; l = '{0, 1, 1};
        check_seq(0, "b2b_lsb", e, l, 1'b1);
        e = '{7, 0, 4};
        check_seq(1, "b2b_msb", e, l, 1'b1);

        // Backpressure holds the first index.
        clr_logs();
        out_rdy = 1'b0;
        send(8'h0C);
        idle(4);
        chk("bp_hold_idx", idx_a[0], 2);
        chk("bp_hold_lst", out_lst_a[0], 0);
        chk("bp_hold_vld", out_vld_a[0], 1);
        out_rdy = 1'b1;
        idle(4);
        e = '{2, 3}; l = '{0, 1};
        check_seq(0, "bp_lsb", e, l, 1'b1);

        // Reset after three transfers of an all-ones vector drops the rest.
        clr_logs();
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(6);
        e = '{0, 1, 2}; l = '{0, 0, 0};
        check_seq(0, "rst_lsb", e, l, 1'b1);
        e = '{7, 6, 5};
        check_seq(1, "rst_msb", e, l, 1'b1);
        chk("rst_after_vld", out_vld_a[0], 0);

        // Empty vector is absorbed silently.
        clr_logs();
        send(8'h00);
        chk("zero_in_rdy", in_rdy_a[2], 1);
        chk("zero_vld", out_vld_a[2], 0);
        idle(3);
        chk("zero_count5", log_idx[2].size(), 0);
        chk("zero_count5m", log_idx[3].size(), 0);

        // Full 5-bit vector on both encoder implementations.
        clr_logs();
        send(8'h1F);
        idle(8);
        e = '{0, 1, 2, 3, 4}; l = '{0, 0, 0, 0, 1};
        check_seq(2, "full5_lsb", e, l, 1'b1);
        e = '{4, 3, 2, 1, 0};
        check_seq(3, "full5_msb", e, l, 1'b1);

        // Randomized traffic, occasional reset; the model checks every cycle.
        for (int c = 0; c < 600; c++) begin
            in_vld  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0:       in_vec = 8'h00;
                1:       in_vec = 8'hFF;
                default: in_vec = 8'($urandom);
            endcase
            out_rdy = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        idle(12);
        for (int d = 0; d < 4; d++)
            chk($sformatf("drain_busy%0d", d), busy_a[d], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multihot_index_scanner.md
Name: multihot_index_scanner

Overview:
- Sequential successor to the one-hot encoder: accepts a multi-hot vector over a valid/ready handshake and emits the index of every set bit, one index per output transfer.
- Bit order is selectable: LSB-first or MSB-first.
- Sits between request bitmaps (interrupt pending, free-slot maps, arbitration masks) and index-consuming logic that takes one index per cycle.
- Internally isolates one bit per cycle and encodes it with the existing one-hot encoder.

Parameters:
- WIDTH, 32, input vector width; must be >= 2.
- WIDTH_LOG, $clog2(WIDTH), localparam, index width.
- IMPLEMENTATION, 0, passed to the one-hot encoder (0 loop, 1 table); other values give $fatal at elaboration.
- DIRECTION, SCAN_LSB, scan order (SCAN_LSB or SCAN_MSB, from package).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_vld  input  1  input vector valid.
- in_rdy  output  1  scanner can accept a vector.
- in_vec  input  WIDTH  multi-hot vector to scan.
- out_vld  output  1  enc_idx valid.
- out_rdy  input  1  consumer accepts index.
- enc_idx  output  WIDTH_LOG  index of current set bit.
- out_lst  output  1  current index is the last set bit of this vector.
- busy  output  1  a vector is loaded and not yet drained.

Behaviour:
- State: remaining-mask register msk[WIDTH-1:0]; busy = |msk. No other state register.
- Reset: msk = 0. Outputs after reset: out_vld=0, in_rdy=1, busy=0, out_lst=0, enc_idx=0.
- Reset asserted mid-scan clears msk immediately and drops the remaining indices. There is no flush handshake.
- Selection is combinational on msk:
  - SCAN_LSB: sel = msk & (~msk + 1).
  - SCAN_MSB: bit-reverse msk, isolate the lowest set bit, reverse the result back.
  - sel is always one-hot or zero. It drives the encoder, which produces enc_idx.
- out_vld = busy. enc_idx is valid only while out_vld=1 and must be held stable while out_vld=1 and out_rdy=0.
- out_lst = out_vld and (msk & ~sel) == 0.
- Output transfer (out_vld & out_rdy): msk <= msk & ~sel.
- in_rdy = ~busy | (out_vld & out_rdy & out_lst). This gives zero-bubble back-to-back vectors.
- Input transfer (in_vld & in_rdy): msk <= in_vec. This takes priority over the clear from the same-cycle final output transfer.
- Latency: the first index appears on out_vld in the cycle after input acceptance. Each further index takes one cycle under continuous out_rdy=1.
- A vector with k set bits occupies the scanner for exactly k output transfers.
- in_vec = 0 is accepted and produces no output transfer. msk stays 0 and in_rdy stays 1.
- Backpressure: out_rdy=0 holds msk, enc_idx and out_lst unchanged. in_rdy=0 while busy.
- in_vec is sampled only on acceptance. Changes at other times are ignored.
- Full vector (all ones): WIDTH transfers in order 0..WIDTH-1 for LSB, or WIDTH-1..0 for MSB. out_lst is set on the last one.
- Non-power-of-two WIDTH: enc_idx never exceeds WIDTH-1.

Decomposition:
- Package onehot_pkg holds:
  - enum scan_dir_t {SCAN_LSB, SCAN_MSB};
  - helper function bit_reverse_f(WIDTH-generic via parameterised class or per-use loop).
- Index width stays local as WIDTH_LOG.
- One sub-module: onehot_encoder_base (WIDTH, IMPLEMENTATION). It is instantiated once on sel; its enc_vld output is unused or asserted equal to busy.
- Assertions (bench or bind):
  - sel is $onehot0.
  - enc_idx is stable under out_rdy=0.
  - A new vector is never accepted while busy unless it coincides with the last output transfer.

Test Plan:
- Reset then idle, WIDTH=8 LSB -> in_rdy=1, out_vld=0, busy=0. Assert rst mid-scan of 8'hFF after 3 transfers -> next cycle out_vld=0, in_rdy=1, no further indices.
- WIDTH=8 LSB, in_vec=8'b1010_0110, out_rdy=1 -> indices 1,2,5,7 on consecutive cycles, out_lst only with 7, in_rdy high in the cycle of index 7.
- Same vector with DIRECTION=SCAN_MSB -> indices 7,5,2,1, out_lst with 1.
- Back-to-back: 8'h81 then 8'h10 with in_vld held -> indices 0,7,4 on three consecutive cycles with no bubble, second vector accepted in the cycle index 7 transfers.
- Backpressure: 8'h0C, out_rdy=0 for 4 cycles -> enc_idx=2 held stable, out_lst=0. Then out_rdy=1 -> 2, then 3 with out_lst=1.
- Edge vectors, WIDTH=5 with both IMPLEMENTATION values:
  - in_vec=0 -> no out_vld, in_rdy stays 1.
  - in_vec=5'h1F -> indices 0..4, max enc_idx=4.
  - Random vectors checked against a reference model for count, order and last-flag.
